// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: h/v counters, sync/data-enable and pixel output, all registered one clock after the counters.
// Define LCD_TIMING_PATTERN_EN to build the test-pattern generator; without it, pixels come from solid_rgb.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 1366,
  parameter int H_FP     = 30,
  parameter int H_SYNC   = 114,
  parameter int H_BP     = 30,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 4,
  parameter bit SYNC_POL = 1'b1,
  parameter int COLOR_W  = 6,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic [HW-1:0]          pos_x,
  output logic [VW-1:0]          pos_y,
  output logic                   sof
);

  logic [HW-1:0]        h;
  logic [VW-1:0]        v;
  logic [31:0]          hx, vx;
  logic                 h_last, v_last;
  logic                 de_n, hs_n, vs_n, sof_n;
  logic [3*COLOR_W-1:0] rgb_n, pix;

  assign hx     = 32'(h);
  assign vx     = 32'(v);
  assign h_last = (hx == 32'(H_TOTAL - 1));
  assign v_last = (vx == 32'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Everything below is gated by en so a stopped generator presents idle outputs immediately.
  assign de_n  = en && (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
  assign hs_n  = en && (hx >= 32'(H_ACTIVE + H_FP)) && (hx < 32'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_n  = en && (vx >= 32'(V_ACTIVE + V_FP)) && (vx < 32'(V_ACTIVE + V_FP + V_SYNC));
  assign sof_n = en && (h == '0) && (v == '0);

`ifdef LCD_TIMING_PATTERN_EN
  logic [1:0] mode_q, mode_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'd0;
    end else if (sof_n) begin
      mode_q <= mode;
    end
  end

  // The first pixel of a frame already uses the newly sampled mode, so a frame is never mixed.
  assign mode_eff = sof_n ? mode : mode_q;

  always_comb begin
    pix = '0;
    case (mode_eff)
      2'd0: begin
        if (hx < 32'(H_ACTIVE / 4))
          pix = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};
        else if (hx < 32'(H_ACTIVE / 2))
          pix = {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}};
        else if (hx < 32'((3 * H_ACTIVE) / 4))
          pix = {{(2*COLOR_W){1'b0}}, {COLOR_W{1'b1}}};
        else
          pix = '1;
      end
      2'd1:    pix = {3{COLOR_W'(h)}};
      2'd2:    pix = ((((hx >> 5) ^ (vx >> 5)) & 32'd1) != 32'd0) ? '1 : '0;
      default: pix = solid_rgb;
    endcase
  end
`else
  logic unused_mode;

  assign unused_mode = ^mode;
  assign pix         = solid_rgb;
`endif

  assign rgb_n = de_n ? pix : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      de    <= 1'b0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      sof   <= 1'b0;
      pos_x <= '0;
      pos_y <= '0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      de    <= de_n;
      hsync <= hs_n ? SYNC_POL : ~SYNC_POL;
      vsync <= vs_n ? SYNC_POL : ~SYNC_POL;
      sof   <= sof_n;
      pos_x <= en ? h : '0;
      pos_y <= en ? v : '0;
      red   <= rgb_n[3*COLOR_W-1:2*COLOR_W];
      green <= rgb_n[2*COLOR_W-1:COLOR_W];
      blue  <= rgb_n[COLOR_W-1:0];
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 15x8 total raster, with positive- and negative-polarity instances.
module tb_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic [17:0] solid_rgb;

  logic       hsync, vsync, de, sof;
  logic [5:0] red, green, blue;
  logic [3:0] pos_x;
  logic [2:0] pos_y;

  logic       hsync_n, vsync_n, de_n, sof_n;
  logic [5:0] red_n, green_n, blue_n;
  logic [3:0] pos_x_n;
  logic [2:0] pos_y_n;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .COLOR_W(6)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .pos_x(pos_x), .pos_y(pos_y), .sof(sof)
  );

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .COLOR_W(6)
  ) u_dut_n (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync_n), .vsync(vsync_n), .de(de_n),
    .red(red_n), .green(green_n), .blue(blue_n),
    .pos_x(pos_x_n), .pos_y(pos_y_n), .sof(sof_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] exp_rgb(input int x, input int y, input int m);
    logic [5:0] xs;
    xs = 6'(x);
    if (!(x < 8 && y < 4)) return 18'h0;
    case (m)
      0: begin
        if (x < 2)      return 18'h3F000;
        else if (x < 4) return 18'h00FC0;
        else if (x < 6) return 18'h0003F;
        else            return 18'h3FFFF;
      end
      1:       return {xs, xs, xs};
      2:       return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 18'h3FFFF : 18'h0;
      default: return solid_rgb;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_de"},    32'(de),    0);
    check({tag, "_hsync"}, 32'(hsync), 0);
    check({tag, "_vsync"}, 32'(vsync), 0);
    check({tag, "_sof"},   32'(sof),   0);
    check({tag, "_posx"},  32'(pos_x), 0);
    check({tag, "_posy"},  32'(pos_y), 0);
    check({tag, "_rgb"},   32'({red, green, blue}), 0);
    check({tag, "_hsync_n"}, 32'(hsync_n), 1);
    check({tag, "_vsync_n"}, 32'(vsync_n), 1);
    check({tag, "_de_n"},    32'(de_n),    0);
  endtask

  task automatic check_pixel(input int k, input int m);
    int x, y;
    bit hs, vs;
    x  = k % 15;
    y  = (k / 15) % 8;
    hs = (x >= 10) && (x < 13);
    vs = (y == 5) || (y == 6);
    check("posx",    32'(pos_x),   32'(x));
    check("posy",    32'(pos_y),   32'(y));
    check("de",      32'(de),      32'((x < 8) && (y < 4)));
    check("hsync",   32'(hsync),   32'(hs));
    check("vsync",   32'(vsync),   32'(vs));
    check("hsync_n", 32'(hsync_n), 32'(!hs));
    check("vsync_n", 32'(vsync_n), 32'(!vs));
    check("sof",     32'(sof),     32'((x == 0) && (y == 0)));
    check("rgb",     32'({red, green, blue}), 32'(exp_rgb(x, y, m)));
  endtask

  initial begin
    int m;
    rst       = 1'b1;
    en        = 1'b0;
    mode      = 2'd0;
    solid_rgb = 18'h3F000;
    repeat (3) @(negedge clk);
    check_reset("reset");

    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k < 360; k++) begin
      @(negedge clk);
`ifdef LCD_TIMING_PATTERN_EN
      m = (k >= 240) ? 3 : 0;
`else
      m = 3;
`endif
      check_pixel(k, m);
      if (k == 140) mode = 2'd3;
    end

    // Advance until the counter holds h=5, v=2, then drop en.
    repeat (35) @(negedge clk);
    check("pre_drop_posx", 32'(pos_x), 4);
    check("pre_drop_posy", 32'(pos_y), 2);
    en = 1'b0;
    @(negedge clk);
    check("drop_de",    32'(de),    0);
    check("drop_posx",  32'(pos_x), 0);
    check("drop_posy",  32'(pos_y), 0);
    check("drop_sof",   32'(sof),   0);
    check("drop_hsync", 32'(hsync), 0);
    check("drop_vsync", 32'(vsync), 0);
    check("drop_rgb",   32'({red, green, blue}), 0);
    repeat (3) begin
      @(negedge clk);
      check("hold_de",      32'(de),      0);
      check("hold_posx",    32'(pos_x),   0);
      check("hold_sof",     32'(sof),     0);
      check("hold_hsync_n", 32'(hsync_n), 1);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume_sof",  32'(sof),   1);
    check("resume_posx", 32'(pos_x), 0);
    check("resume_posy", 32'(pos_y), 0);
    check("resume_de",   32'(de),    1);
    @(negedge clk);
    check("resume2_sof",  32'(sof),   0);
    check("resume2_posx", 32'(pos_x), 1);
    @(negedge clk);
    check("pre_rst_de", 32'(de), 1);
    check("pre_rst_rgb_nz", 32'({red, green, blue} != 18'h0), 1);

    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sof",  32'(sof),   1);
    check("post_rst_posx", 32'(pos_x), 0);
    @(negedge clk);
    check("post_rst_posx1", 32'(pos_x), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
